// File: rtl/sampling_layer_param.sv
// Multi-channel POOLxPOOL max/average pooling over a raster-order pixel stream.
// One partial row of window accumulators per channel; results one cycle after the closing beat.
module sampling_layer_param #(
    parameter int CHANNELS = 12,
    parameter int DATA_W   = 16,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int POOL     = 2,
    parameter int MODE     = 0
) (
    input  logic                       Clock,
    input  logic                       Input_Reset,
    input  logic                       Input_Valid,
    input  logic                       Input_Finish,
    input  logic [CHANNELS*DATA_W-1:0] Input_Pixel,
    output logic [CHANNELS*DATA_W-1:0] Output_Pixel,
    output logic                       Output_Valid,
    output logic                       Output_Finish,
    output logic                       Busy
);

    generate
        if (POOL != 2 && POOL != 4) begin : g_bad_pool
            $error("sampling_layer_param: POOL must be 2 or 4");
        end
    endgenerate

    localparam int LP    = (POOL == 4) ? 2 : 1;
    localparam int SH    = 2 * LP;
    localparam int ACC_W = DATA_W + SH;
    localparam int NWIN  = IMG_W / POOL;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int WIW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ABORT
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic signed [ACC_W-1:0] acc_q [CHANNELS][NWIN];
    logic signed [ACC_W-1:0] acc_d [CHANNELS][NWIN];

    logic [CHANNELS*DATA_W-1:0] pix_q, pix_d;
    logic                       valid_q, valid_d;
    logic                       fin_q, fin_d;

    logic                       beat;
    logic                       abort;
    logic                       first_px;
    logic                       win_done;
    logic                       frame_last;
    logic [WIW-1:0]             win;
    logic signed [ACC_W-1:0]    comb_v [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] res_v;

    // Abort takes priority over a pixel presented in the same cycle.
    assign abort = (state_q == S_RUN) && Input_Finish;
    assign beat  = Input_Valid &&
                   ((state_q == S_IDLE) ||
                    ((state_q == S_RUN) && !Input_Finish));

    assign win        = WIW'(col_q >> LP);
    assign first_px   = (col_q[LP-1:0] == '0) && (row_q[LP-1:0] == '0);
    assign win_done   = (col_q[LP-1:0] == LP'(POOL - 1)) &&
                        (row_q[LP-1:0] == LP'(POOL - 1));
    assign frame_last = (col_q == CW'(IMG_W - 1)) &&
                        (row_q == RW'(IMG_H - 1));

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic signed [ACC_W-1:0] px_ext;
            logic signed [ACC_W-1:0] cur;
            logic signed [ACC_W-1:0] comb;

            assign px_ext = {{SH{Input_Pixel[g*DATA_W+DATA_W-1]}},
                             Input_Pixel[g*DATA_W +: DATA_W]};
            assign cur    = acc_q[g][win];

            if (MODE == 1) begin : g_avg
                assign comb = first_px ? px_ext : (cur + px_ext);
                // Floor division by POOL*POOL; the mean always fits DATA_W.
                assign res_v[g*DATA_W +: DATA_W] = DATA_W'(comb >>> SH);
            end else begin : g_max
                assign comb = (first_px || (px_ext > cur)) ? px_ext : cur;
                assign res_v[g*DATA_W +: DATA_W] = comb[DATA_W-1:0];
            end

            assign comb_v[g] = comb;
        end
    endgenerate

    always_comb begin
        acc_d   = acc_q;
        pix_d   = pix_q;
        valid_d = 1'b0;
        fin_d   = 1'b0;
        col_d   = col_q;
        row_d   = row_q;

        if (beat) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_d[c][win] = comb_v[c];
            end
            if (win_done) begin
                valid_d = 1'b1;
                pix_d   = res_v;
            end
            if (frame_last) begin
                fin_d = 1'b1;
            end
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (abort) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int w = 0; w < NWIN; w++) begin
                    acc_d[c][w] = '0;
                end
            end
            col_d = '0;
            row_d = '0;
            fin_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (Input_Valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Input_Finish) begin
                    state_d = S_ABORT;
                end else if (Input_Valid && frame_last) begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Input_Reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            fin_q   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int w = 0; w < NWIN; w++) begin
                    acc_q[c][w] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            fin_q   <= fin_d;
            acc_q   <= acc_d;
        end
    end

    assign Output_Pixel  = pix_q;
    assign Output_Valid  = valid_q;
    assign Output_Finish = fin_q;
    assign Busy          = (state_q == S_RUN);

endmodule

// File: tb/tb_sampling_layer_param.sv
// Directed bench: a max-pooling and an average-pooling instance share one stimulus stream
// over a 2-channel 4x4 map with 2x2 windows.
module tb_sampling_layer_param;

    localparam int CH = 2;
    localparam int DW = 16;

    logic               Clock = 1'b0;
    logic               Input_Reset;
    logic               Input_Valid;
    logic               Input_Finish;
    logic [CH*DW-1:0]   Input_Pixel;
    logic [CH*DW-1:0]   pix_m, pix_a;
    logic               vm, va, fm, fa, bm, ba;

    int checks   = 0;
    int failures = 0;

    int px0 [16];
    int px1 [16];
    int ex_m0 [4];
    int ex_m1 [4];
    int ex_a0 [4];
    int ex_a1 [4];

    logic [31:0] lastm, lasta;

    always #5 Clock = ~Clock;

    sampling_layer_param #(
        .CHANNELS(CH), .DATA_W(DW), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(0)
    ) u_max (
        .Clock(Clock), .Input_Reset(Input_Reset), .Input_Valid(Input_Valid),
        .Input_Finish(Input_Finish), .Input_Pixel(Input_Pixel),
        .Output_Pixel(pix_m), .Output_Valid(vm), .Output_Finish(fm), .Busy(bm)
    );

    sampling_layer_param #(
        .CHANNELS(CH), .DATA_W(DW), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(1)
    ) u_avg (
        .Clock(Clock), .Input_Reset(Input_Reset), .Input_Valid(Input_Valid),
        .Input_Finish(Input_Finish), .Input_Pixel(Input_Pixel),
        .Output_Pixel(pix_a), .Output_Valid(va), .Output_Finish(fa), .Busy(ba)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ctrl(input string tag, input logic v, input logic f,
                        input logic b);
        check({tag, "_valid_max"}, 32'(vm), 32'(v));
        check({tag, "_valid_avg"}, 32'(va), 32'(v));
        check({tag, "_finish_max"}, 32'(fm), 32'(f));
        check({tag, "_finish_avg"}, 32'(fa), 32'(f));
        check({tag, "_busy_max"}, 32'(bm), 32'(b));
        check({tag, "_busy_avg"}, 32'(ba), 32'(b));
    endtask

    task automatic pix(input string tag);
        check({tag, "_pix_max"}, pix_m, lastm);
        check({tag, "_pix_avg"}, pix_a, lasta);
    endtask

    task automatic cyc(input logic r, input logic v, input logic f,
                       input logic [15:0] a, input logic [15:0] b);
        Input_Reset  = r;
        Input_Valid  = v;
        Input_Finish = f;
        Input_Pixel  = {b, a};
        @(posedge Clock);
        #1;
        Input_Reset  = 1'b0;
        Input_Valid  = 1'b0;
        Input_Finish = 1'b0;
    endtask

    task automatic load_a();
        for (int i = 0; i < 16; i++) begin
            px0[i] = i;
            px1[i] = -i;
        end
        ex_m0 = '{5, 7, 13, 15};
        ex_m1 = '{0, -2, -8, -10};
        ex_a0 = '{2, 4, 10, 12};
        ex_a1 = '{-3, -5, -11, -13};
    endtask

    task automatic load_b();
        px0 = '{-1, -2, 32767, 32767, -3, -4, 32767, 32767,
                -32768, -32768, 10, 20, -32768, -32768, 30, 41};
        px1 = '{1, 2, -32768, 32767, 3, 4, -32768, 32767,
                32767, 32767, -1, 0, 32767, 32767, 0, 0};
        ex_m0 = '{-1, 32767, -32768, 41};
        ex_a0 = '{-3, 32767, -32768, 25};
        ex_m1 = '{4, 32767, 32767, 0};
        ex_a1 = '{2, -1, 32767, -1};
    endtask

    task automatic run_frame(input string tag, input int maxgap, input int nb);
        int  w;
        int  gaps;
        logic done;
        w = 0;
        for (int i = 0; i < nb; i++) begin
            gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gaps) begin
                cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                ctrl({tag, "_gap"}, 1'b0, 1'b0, i > 0);
                pix({tag, "_gap"});
            end
            cyc(1'b0, 1'b1, 1'b0, 16'(px0[i]), 16'(px1[i]));
            done = ((i % 4) % 2 == 1) && ((i / 4) % 2 == 1);
            if (done) begin
                lastm = {16'(ex_m1[w]), 16'(ex_m0[w])};
                lasta = {16'(ex_a1[w]), 16'(ex_a0[w])};
                w++;
            end
            ctrl($sformatf("%s_b%0d", tag, i), done, i == 15, i != 15);
            pix($sformatf("%s_b%0d", tag, i));
        end
    endtask

    initial begin
        Input_Reset  = 1'b1;
        Input_Valid  = 1'b0;
        Input_Finish = 1'b0;
        Input_Pixel  = '0;
        lastm = '0;
        lasta = '0;

        cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);
        ctrl("reset", 1'b0, 1'b0, 1'b0);
        pix("reset");

        cyc(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        ctrl("idle_finish", 1'b0, 1'b0, 1'b0);

        load_a();
        run_frame("t1", 0, 16);

        load_b();
        run_frame("t3", 0, 16);

        load_a();
        run_frame("t4", 3, 16);

        run_frame("t5", 0, 6);
        cyc(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0100);
        ctrl("t5_abort", 1'b0, 1'b1, 1'b0);
        pix("t5_abort");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        ctrl("t5_after", 1'b0, 1'b0, 1'b0);
        run_frame("t5_full", 0, 16);

        run_frame("t6", 0, 9);
        cyc(1'b1, 1'b1, 1'b1, 16'h0055, 16'h0055);
        lastm = '0;
        lasta = '0;
        ctrl("t6_reset", 1'b0, 1'b0, 1'b0);
        pix("t6_reset");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        ctrl("t6_after", 1'b0, 1'b0, 1'b0);
        run_frame("t6_full", 0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
